// File: rtl/tap_controller_pkg.sv
// TAP controller shared definitions: state width and the 16 TAP state codes.
package tap_controller_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        exit2_dr_c         = 4'h0,
        exit1_dr_c         = 4'h1,
        shift_dr_c         = 4'h2,
        pause_dr_c         = 4'h3,
        select_ir_c        = 4'h4,
        update_dr_c        = 4'h5,
        capture_dr_c       = 4'h6,
        select_dr_c        = 4'h7,
        exit2_ir_c         = 4'h8,
        exit1_ir_c         = 4'h9,
        shift_ir_c         = 4'hA,
        pause_ir_c         = 4'hB,
        run_test_idle_c    = 4'hC,
        update_ir_c        = 4'hD,
        capture_ir_c       = 4'hE,
        test_logic_reset_c = 4'hF
    } tap_state_t;

    // True for every state on the IR side of the diagram (select_ir through update_ir).
    function automatic logic is_ir_state(tap_state_t s);
        return (s == select_ir_c) || (s == capture_ir_c) || (s == shift_ir_c) ||
               (s == exit1_ir_c)  || (s == pause_ir_c)   || (s == exit2_ir_c) ||
               (s == update_ir_c);
    endfunction

endpackage

// File: rtl/tap_controller_if.sv
// TAP control bundle: tms in, state plus IR/DR strobes and tdo control out.
interface tap_controller_if;
    import tap_controller_pkg::*;

    logic       tms;
    tap_state_t state;
    logic       clkIR;
    logic       shIR;
    logic       upIR;
    logic       clkDR;
    logic       shDR;
    logic       upDR;
    logic       tl_rst_n;
    logic       sel_ir;
    logic       tdo_en;

    modport master (
        input  tms,
        output state, clkIR, shIR, upIR, clkDR, shDR, upDR, tl_rst_n, sel_ir, tdo_en
    );

    modport slave (
        output tms,
        input  state, clkIR, shIR, upIR, clkDR, shDR, upDR, tl_rst_n, sel_ir, tdo_en
    );

endinterface

// File: rtl/tap_clock_gate.sv
// Glitch-free clock gate: enable captured on falling tck, ANDed with tck.
module tap_clock_gate (
    input  logic tck,
    input  logic reset,
    input  logic en,
    output logic gclk
);

    logic en_q;

    // Enable only moves while tck is low, so the AND output cannot produce a runt pulse.
    always_ff @(negedge tck or negedge reset) begin
        if (!reset) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en;
        end
    end

    assign gclk = tck & en_q;

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP state machine with IR/DR capture/shift/update strobes.
module tap_controller
    import tap_controller_pkg::*;
(
    input  logic             tck,
    input  logic             reset,
    tap_controller_if.master bus
);

    tap_state_t state_q;
    tap_state_t state_d;
    logic       irclk_en;
    logic       drclk_en;
    logic       clk_ir;
    logic       clk_dr;
    logic       sh_ir_q;
    logic       sh_dr_q;
    logic       tl_rst_n_q;
    logic       tdo_en_q;
    logic       sel_ir_q;

    // Next state from the standard tms transition table.
    always_comb begin
        state_d = state_q;
        case (state_q)
            test_logic_reset_c: state_d = bus.tms ? test_logic_reset_c : run_test_idle_c;
            run_test_idle_c:    state_d = bus.tms ? select_dr_c        : run_test_idle_c;
            select_dr_c:        state_d = bus.tms ? select_ir_c        : capture_dr_c;
            capture_dr_c:       state_d = bus.tms ? exit1_dr_c         : shift_dr_c;
            shift_dr_c:         state_d = bus.tms ? exit1_dr_c         : shift_dr_c;
            exit1_dr_c:         state_d = bus.tms ? update_dr_c        : pause_dr_c;
            pause_dr_c:         state_d = bus.tms ? exit2_dr_c         : pause_dr_c;
            exit2_dr_c:         state_d = bus.tms ? update_dr_c        : shift_dr_c;
            update_dr_c:        state_d = bus.tms ? select_dr_c        : run_test_idle_c;
            select_ir_c:        state_d = bus.tms ? test_logic_reset_c : capture_ir_c;
            capture_ir_c:       state_d = bus.tms ? exit1_ir_c         : shift_ir_c;
            shift_ir_c:         state_d = bus.tms ? exit1_ir_c         : shift_ir_c;
            exit1_ir_c:         state_d = bus.tms ? update_ir_c        : pause_ir_c;
            pause_ir_c:         state_d = bus.tms ? exit2_ir_c         : pause_ir_c;
            exit2_ir_c:         state_d = bus.tms ? update_ir_c        : shift_ir_c;
            update_ir_c:        state_d = bus.tms ? select_dr_c        : run_test_idle_c;
            default:            state_d = test_logic_reset_c;
        endcase
    end

    // TAP state register; reset holds test_logic_reset without sampling tms.
    always_ff @(posedge tck or negedge reset) begin
        if (!reset) begin
            state_q <= test_logic_reset_c;
        end else begin
            state_q <= state_d;
        end
    end

    // Control outputs registered on falling tck so they are stable around the next rising edge.
    always_ff @(negedge tck or negedge reset) begin
        if (!reset) begin
            sh_ir_q    <= 1'b0;
            sh_dr_q    <= 1'b0;
            tl_rst_n_q <= 1'b0;
            tdo_en_q   <= 1'b0;
            sel_ir_q   <= 1'b1;
        end else begin
            sh_ir_q    <= (state_q == shift_ir_c);
            sh_dr_q    <= (state_q == shift_dr_c);
            tl_rst_n_q <= (state_q != test_logic_reset_c);
            tdo_en_q   <= (state_q == shift_ir_c) || (state_q == shift_dr_c);
            sel_ir_q   <= is_ir_state(state_q) || (state_q == test_logic_reset_c);
        end
    end

    assign irclk_en = (state_q == capture_ir_c) || (state_q == shift_ir_c);
    assign drclk_en = (state_q == capture_dr_c) || (state_q == shift_dr_c);

    tap_clock_gate u_gate_ir (
        .tck   (tck),
        .reset (reset),
        .en    (irclk_en),
        .gclk  (clk_ir)
    );

    tap_clock_gate u_gate_dr (
        .tck   (tck),
        .reset (reset),
        .en    (drclk_en),
        .gclk  (clk_dr)
    );

    assign bus.state    = state_q;
    assign bus.clkIR    = clk_ir;
    assign bus.clkDR    = clk_dr;
    assign bus.shIR     = sh_ir_q;
    assign bus.shDR     = sh_dr_q;
    assign bus.tl_rst_n = tl_rst_n_q;
    assign bus.tdo_en   = tdo_en_q;
    assign bus.sel_ir   = sel_ir_q;
    // Update strobes pulse low only during the tck-low half of the update state.
    assign bus.upIR     = ~((state_q == update_ir_c) & ~tck);
    assign bus.upDR     = ~((state_q == update_dr_c) & ~tck);

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: directed TAP walks, exhaustive transitions, random tms.
module tb_tap_controller;
    import tap_controller_pkg::*;

    logic tck = 1'b0;
    logic reset = 1'b0;
    tap_controller_if bus();

    tap_controller dut (
        .tck   (tck),
        .reset (reset),
        .bus   (bus)
    );

    always #5 tck = ~tck;

    int total = 0;
    int bad = 0;
    logic [3:0] nx0 [16];
    logic [3:0] nx1 [16];
    logic [3:0] m;
    int up_ir_model = 0;
    int up_dr_model = 0;
    int up_ir_seen = 0;
    int up_dr_seen = 0;
    int par [16];
    bit pb [16];

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Gated clocks may only rise with tck and only fall with tck or under reset.
    always @(posedge bus.clkIR) begin
        total++;
        assert ((($time % 10) == 5) && tck === 1'b1) else begin
            bad++;
            $error("FAIL clkir_rise t=%0t observed tck=%b expected aligned rise", $time, tck);
        end
    end
    always @(negedge bus.clkIR) begin
        total++;
        assert (reset === 1'b0 || (($time % 10) == 0)) else begin
            bad++;
            $error("FAIL clkir_fall t=%0t observed misaligned expected aligned fall", $time);
        end
    end
    always @(posedge bus.clkDR) begin
        total++;
        assert ((($time % 10) == 5) && tck === 1'b1) else begin
            bad++;
            $error("FAIL clkdr_rise t=%0t observed tck=%b expected aligned rise", $time, tck);
        end
    end
    always @(negedge bus.clkDR) begin
        total++;
        assert (reset === 1'b0 || (($time % 10) == 0)) else begin
            bad++;
            $error("FAIL clkdr_fall t=%0t observed misaligned expected aligned fall", $time);
        end
    end
    always @(negedge bus.upIR) up_ir_seen++;
    always @(negedge bus.upDR) up_dr_seen++;

    function automatic logic is_ir(input logic [3:0] s);
        return s inside {4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
    endfunction

    task automatic tbl(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
        nx0[s] = a;
        nx1[s] = b;
    endtask

    // Expected tck-low view of all outputs for model state m.
    task automatic check_low();
        chk("state_low", bus.state, m);
        chk("shir", bus.shIR, 4'(m == 4'hA));
        chk("shdr", bus.shDR, 4'(m == 4'h2));
        chk("tl_rst_n", bus.tl_rst_n, 4'(m != 4'hF));
        chk("tdo_en", bus.tdo_en, 4'(m == 4'hA || m == 4'h2));
        chk("sel_ir", bus.sel_ir, 4'(is_ir(m) || m == 4'hF));
        chk("clkir_low", bus.clkIR, 4'h0);
        chk("clkdr_low", bus.clkDR, 4'h0);
        chk("upir_low", bus.upIR, 4'(m != 4'hD));
        chk("updr_low", bus.upDR, 4'(m != 4'h5));
    endtask

    // One tck cycle; entered and left at falling tck + 1.
    task automatic step(input logic b);
        logic [3:0] prev;
        bus.tms = b;
        prev = m;
        m = b ? nx1[m] : nx0[m];
        if (m == 4'hD) up_ir_model++;
        if (m == 4'h5) up_dr_model++;
        @(posedge tck);
        #1;
        chk("state", bus.state, m);
        chk("upir_high", bus.upIR, 4'h1);
        chk("updr_high", bus.upDR, 4'h1);
        #2;
        chk("clkir_high", bus.clkIR, 4'(prev == 4'hE || prev == 4'hA));
        chk("clkdr_high", bus.clkDR, 4'(prev == 4'h6 || prev == 4'h2));
        @(negedge tck);
        #1;
        check_low();
    endtask

    task automatic steps(input bit seq [$]);
        foreach (seq[i]) step(seq[i]);
    endtask

    // Reach any state from TLR along a shortest tms path found by search on the model table.
    task automatic goto_state(input logic [3:0] target);
        bit seq [$];
        int v;
        repeat (5) step(1'b1);
        chk("five_ones_tlr", bus.state, 4'hF);
        v = target;
        while (v != 15) begin
            seq.push_front(pb[v]);
            v = par[v];
        end
        steps(seq);
    endtask

    task automatic reset_low_phase();
        reset = 1'b0;
        m = 4'hF;
        #1;
        check_low();
        bus.tms = 1'($urandom_range(0, 1));
        @(posedge tck);
        #1;
        chk("tms_ignored_in_reset", bus.state, 4'hF);
        @(negedge tck);
        #1;
        reset = 1'b1;
        check_low();
    endtask

    initial begin
        bit seen [16];
        int q [$];
        int u;
        int v;

        tbl(4'hF, 4'hC, 4'hF); tbl(4'hC, 4'hC, 4'h7);
        tbl(4'h7, 4'h6, 4'h4); tbl(4'h4, 4'hE, 4'hF);
        tbl(4'h6, 4'h2, 4'h1); tbl(4'h2, 4'h2, 4'h1);
        tbl(4'h1, 4'h3, 4'h5); tbl(4'h3, 4'h3, 4'h0);
        tbl(4'h0, 4'h2, 4'h5); tbl(4'h5, 4'hC, 4'h7);
        tbl(4'hE, 4'hA, 4'h9); tbl(4'hA, 4'hA, 4'h9);
        tbl(4'h9, 4'hB, 4'hD); tbl(4'hB, 4'hB, 4'h8);
        tbl(4'h8, 4'hA, 4'hD); tbl(4'hD, 4'hC, 4'h7);

        foreach (seen[i]) seen[i] = 1'b0;
        seen[15] = 1'b1;
        q.push_back(15);
        while (q.size() > 0) begin
            u = q.pop_front();
            for (int b = 0; b < 2; b++) begin
                v = (b != 0) ? int'(nx1[u]) : int'(nx0[u]);
                if (!seen[v]) begin
                    seen[v] = 1'b1;
                    par[v] = u;
                    pb[v] = (b != 0);
                    q.push_back(v);
                end
            end
        end

        // Power-on reset with tms wiggling: state held, reset output values.
        m = 4'hF;
        bus.tms = 1'b0;
        repeat (3) begin
            @(negedge tck);
            bus.tms = ~bus.tms;
            #1;
            check_low();
        end
        reset = 1'b1;

        // IR walk into shift_ir, three shifts, exit and update.
        steps('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        steps('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});

        // Reset asserted mid shift_ir while tck is high.
        steps('{1'b1, 1'b1, 1'b0, 1'b0});
        bus.tms = 1'b0;
        @(posedge tck);
        #2;
        chk("clkir_before_reset", bus.clkIR, 4'h1);
        reset = 1'b0;
        m = 4'hF;
        #1;
        chk("rst_state", bus.state, 4'hF);
        chk("rst_clkir", bus.clkIR, 4'h0);
        chk("rst_upir", bus.upIR, 4'h1);
        chk("rst_tl_rst_n", bus.tl_rst_n, 4'h0);
        chk("rst_shir", bus.shIR, 4'h0);
        chk("rst_sel_ir", bus.sel_ir, 4'h1);
        @(negedge tck);
        #1;
        reset = 1'b1;
        check_low();

        // shift_dr then five tms=1 back to TLR.
        steps('{1'b0, 1'b1, 1'b0, 1'b0});
        steps('{1'b1, 1'b1, 1'b1, 1'b1, 1'b1});

        // Full DR path including pause and exit2.
        steps('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});

        // Every state under both tms values.
        for (int s = 0; s < 16; s++) begin
            for (int b = 0; b < 2; b++) begin
                goto_state(4'(s));
                step(b != 0);
            end
        end

        // Random tms with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 3) reset_low_phase();
            else step(1'($urandom_range(0, 1)));
        end

        chk_int("upir_pulse_count", up_ir_seen, up_ir_model);
        chk_int("updr_pulse_count", up_dr_seen, up_dr_model);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
